l2_miss_arbiter: RTL and testbench

// - Shares the single L2 request port between the L1 I-cache and L1 D-cache miss-repair engines.
// - Serialises block refills (I and D) and D-cache dirty writebacks: one L2 transaction in flight.
// - Routes each L2 response back to the requester that owns the in-flight transaction.
// - Orders a D writeback before an I refill of the same block, so the I-cache never refills stale data.

---
 rtl/l2_arb_pkg.sv | 27 ++
 rtl/l2_arb_pick.sv | 39 +++
 rtl/l2_miss_arbiter.sv | 170 +++++++++++++++++
 tb/tb_l2_miss_arbiter.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/l2_arb_pkg.sv
// Shared types and helpers for the L2 miss arbiter.
// Build option: define L2_ARB_RR_EN to replace fixed D-over-I priority with round-robin.
package l2_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } arb_state_t;

    typedef enum logic [1:0] {
        NONE  = 2'd0,
        OWN_I = 2'd1,
        OWN_D = 2'd2
    } arb_owner_t;

    // Widest address the block compare supports; callers zero-extend into it.
    localparam int unsigned ADDR_W_MAX = 64;

    // True when two byte addresses fall into the same cache block.
    function automatic logic same_block(input logic [ADDR_W_MAX-1:0] a,
                                        input logic [ADDR_W_MAX-1:0] b,
                                        input int unsigned           offset_w);
        return (a >> offset_w) == (b >> offset_w);
    endfunction

endpackage

// File: rtl/l2_arb_pick.sv
// Combinational winner select between the I-cache and D-cache miss engines.
// A D writeback to the block an I refill wants always wins, so the I-cache
// never refills stale data. Otherwise D beats I, or, when L2_ARB_RR_EN is
// defined, the side that did not win last time beats the other.
module l2_arb_pick
    import l2_arb_pkg::*;
#(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned OFFSET_W = 7
) (
    input  logic              i_valid_i,
    input  logic [ADDR_W-1:0] i_addr_i,
    input  logic              d_valid_i,
    input  logic [ADDR_W-1:0] d_addr_i,
    input  logic              d_we_i,
`ifdef L2_ARB_RR_EN
    input  logic              last_win_d_i,
`endif
    output logic              grant_i_o,
    output logic              grant_d_o
);

    logic hazard;
    logic d_first;

    // Hazard override first, then the configured priority rule.
    always_comb begin
        hazard = d_valid_i & d_we_i & i_valid_i &
                 same_block(ADDR_W_MAX'(d_addr_i), ADDR_W_MAX'(i_addr_i), OFFSET_W);
`ifdef L2_ARB_RR_EN
        d_first = ~last_win_d_i;
`else
        d_first = 1'b1;
`endif
        grant_d_o = d_valid_i & (hazard | ~i_valid_i | d_first);
        grant_i_o = i_valid_i & ~grant_d_o;
    end

endmodule

// File: rtl/l2_miss_arbiter.sv
// Shares the single L2 request port between the I-cache and D-cache miss
// engines with one transaction in flight, and routes each L2 completion back
// to its owner in the same cycle.
// Build option: L2_ARB_RR_EN selects round-robin priority (hazard rule still wins).
// Handshake: a requester holds valid and payload until it sees ready, which is
// high for exactly one cycle per accept; l2_req_valid holds the latched payload
// until l2_req_ready; resp_valid pulses once per completion.
module l2_miss_arbiter
    import l2_arb_pkg::*;
#(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned OFFSET_W = 7,
    parameter int unsigned BLOCK_W  = 1024
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_req_valid,
    output logic               i_req_ready,
    input  logic [ADDR_W-1:0]  i_req_addr,
    input  logic               d_req_valid,
    output logic               d_req_ready,
    input  logic [ADDR_W-1:0]  d_req_addr,
    input  logic               d_req_we,
    input  logic [BLOCK_W-1:0] d_req_wdata,
    output logic               l2_req_valid,
    input  logic               l2_req_ready,
    output logic [ADDR_W-1:0]  l2_req_addr,
    output logic               l2_req_we,
    output logic [BLOCK_W-1:0] l2_req_wdata,
    input  logic               l2_resp_valid,
    input  logic [BLOCK_W-1:0] l2_resp_rdata,
    output logic               i_resp_valid,
    output logic [BLOCK_W-1:0] i_resp_data,
    output logic               d_resp_valid,
    output logic [BLOCK_W-1:0] d_resp_data,
    output arb_state_t         dbg_state_o
);

    arb_state_t         state_q, state_d;
    arb_owner_t         owner_q, owner_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic               we_q, we_d;
    logic [BLOCK_W-1:0] wdata_q, wdata_d;
    logic               grant_i, grant_d;
`ifdef L2_ARB_RR_EN
    logic               last_win_d_q, last_win_d_d;
`endif

    l2_arb_pick #(
        .ADDR_W   (ADDR_W),
        .OFFSET_W (OFFSET_W)
    ) u_pick (
        .i_valid_i    (i_req_valid),
        .i_addr_i     (i_req_addr),
        .d_valid_i    (d_req_valid),
        .d_addr_i     (d_req_addr),
        .d_we_i       (d_req_we),
`ifdef L2_ARB_RR_EN
        .last_win_d_i (last_win_d_q),
`endif
        .grant_i_o    (grant_i),
        .grant_d_o    (grant_d)
    );

    // State, owner and latched payload; reset drops any in-flight transaction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            owner_q <= NONE;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
        end
    end

`ifdef L2_ARB_RR_EN
    // Last-winner pointer: 1 when D won the most recent accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_win_d_q <= 1'b0;
        end else begin
            last_win_d_q <= last_win_d_d;
        end
    end
`endif

    // Next state, accept strobes and response routing.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        addr_d       = addr_q;
        we_d         = we_q;
        wdata_d      = wdata_q;
`ifdef L2_ARB_RR_EN
        last_win_d_d = last_win_d_q;
`endif
        i_req_ready  = 1'b0;
        d_req_ready  = 1'b0;
        l2_req_valid = 1'b0;
        i_resp_valid = 1'b0;
        i_resp_data  = '0;
        d_resp_valid = 1'b0;
        d_resp_data  = '0;
        case (state_q)
            IDLE: begin
                // Reset is asynchronous, so keep the combinational ready low while it is held.
                if (!rst && grant_d) begin
                    d_req_ready  = 1'b1;
                    owner_d      = OWN_D;
                    addr_d       = d_req_addr;
                    we_d         = d_req_we;
                    wdata_d      = d_req_wdata;
                    state_d      = ISSUE;
`ifdef L2_ARB_RR_EN
                    last_win_d_d = 1'b1;
`endif
                end else if (!rst && grant_i) begin
                    i_req_ready  = 1'b1;
                    owner_d      = OWN_I;
                    addr_d       = i_req_addr;
                    we_d         = 1'b0;
                    wdata_d      = '0;
                    state_d      = ISSUE;
`ifdef L2_ARB_RR_EN
                    last_win_d_d = 1'b0;
`endif
                end
            end
            ISSUE: begin
                l2_req_valid = 1'b1;
                if (l2_req_ready) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (l2_resp_valid) begin
                    state_d = IDLE;
                    owner_d = NONE;
                    if (owner_q == OWN_I) begin
                        i_resp_valid = 1'b1;
                        i_resp_data  = we_q ? '0 : l2_resp_rdata;
                    end else if (owner_q == OWN_D) begin
                        d_resp_valid = 1'b1;
                        d_resp_data  = we_q ? '0 : l2_resp_rdata;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                owner_d = NONE;
            end
        endcase
    end

    assign l2_req_addr  = addr_q;
    assign l2_req_we    = we_q;
    assign l2_req_wdata = wdata_q;
    assign dbg_state_o  = state_q;

    // An L2 completion is only meaningful while a transaction is waiting for it.
    resp_only_in_wait: assert property (@(posedge clk) disable iff (rst)
        l2_resp_valid |-> (state_q == WAIT));

endmodule

// File: tb/tb_l2_miss_arbiter.sv
// Self-checking bench for l2_miss_arbiter: directed scenarios followed by
// randomized traffic, all checked every cycle against a transaction-level model.
module tb_l2_miss_arbiter;
  import l2_arb_pkg::*;

  localparam int ADDR_W   = 32;
  localparam int OFFSET_W = 7;
  localparam int BLOCK_W  = 1024;
  typedef logic [BLOCK_W-1:0] blk_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic              i_req_valid, i_req_ready;
  logic [ADDR_W-1:0] i_req_addr;
  logic              d_req_valid, d_req_ready;
  logic [ADDR_W-1:0] d_req_addr;
  logic              d_req_we;
  blk_t              d_req_wdata;
  logic              l2_req_valid, l2_req_ready;
  logic [ADDR_W-1:0] l2_req_addr;
  logic              l2_req_we;
  blk_t              l2_req_wdata;
  logic              l2_resp_valid;
  blk_t              l2_resp_rdata;
  logic              i_resp_valid, d_resp_valid;
  blk_t              i_resp_data, d_resp_data;
  arb_state_t        dbg_state;

  l2_miss_arbiter #(.ADDR_W(ADDR_W), .OFFSET_W(OFFSET_W), .BLOCK_W(BLOCK_W)) dut (
    .clk(clk), .rst(rst),
    .i_req_valid(i_req_valid), .i_req_ready(i_req_ready), .i_req_addr(i_req_addr),
    .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_addr(d_req_addr),
    .d_req_we(d_req_we), .d_req_wdata(d_req_wdata),
    .l2_req_valid(l2_req_valid), .l2_req_ready(l2_req_ready), .l2_req_addr(l2_req_addr),
    .l2_req_we(l2_req_we), .l2_req_wdata(l2_req_wdata),
    .l2_resp_valid(l2_resp_valid), .l2_resp_rdata(l2_resp_rdata),
    .i_resp_valid(i_resp_valid), .i_resp_data(i_resp_data),
    .d_resp_valid(d_resp_valid), .d_resp_data(d_resp_data),
    .dbg_state_o(dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [ADDR_W-1:0] exp_q[$];  // addresses accepted but not yet taken by L2

  function automatic logic [31:0] fold32(input blk_t v);
    logic [31:0] f = '0;
    for (int k = 0; k < BLOCK_W / 32; k++) f ^= v[k*32 +: 32];
    return f;
  endfunction

  task automatic check(input string tag, input blk_t act, input blk_t exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got ..%h (xor32 %h) expected ..%h (xor32 %h) at %0t",
               tag, act[63:0], fold32(act), exp[63:0], fold32(exp), $time);
    end
  endtask

  // ---------------- reference model state ----------------
  bit                m_busy, m_issued, m_owner_d, m_we, m_last_d;
  logic [ADDR_W-1:0] m_addr;
  blk_t              m_wdata;
  int                m_wait, m_resp_delay;

  // Stimulus controls
  bit                rand_en;
  int                l2_rdy_mode;        // 0 random, 1 always ready, 2 never ready
  int                resp_delay_fixed;   // <0 random
  bit                drop_i, drop_d;
  bit                want_i, want_d, want_d_we;
  logic [ADDR_W-1:0] want_i_addr, want_d_addr;
  int                n_iresp_obs, n_dresp_obs;
  int                win_log[$];         // 1 = D accepted, 0 = I accepted

  function automatic blk_t rand_blk();
    blk_t b;
    for (int k = 0; k < BLOCK_W / 32; k++) b[k*32 +: 32] = $urandom;
    return b;
  endfunction

  function automatic logic [ADDR_W-1:0] rand_addr();
    return 32'h0000_2000 + ($urandom_range(0, 3) << OFFSET_W) + $urandom_range(0, 127);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive();
    if (drop_i) begin i_req_valid = 1'b0; drop_i = 1'b0; end
    if (drop_d) begin d_req_valid = 1'b0; drop_d = 1'b0; end
    if (!i_req_valid) begin
      if (want_i) begin
        i_req_valid = 1'b1; i_req_addr = want_i_addr; want_i = 1'b0;
      end else if (rand_en && $urandom_range(0, 3) == 0) begin
        i_req_valid = 1'b1; i_req_addr = rand_addr();
      end
    end
    if (!d_req_valid) begin
      if (want_d) begin
        d_req_valid = 1'b1; d_req_addr = want_d_addr; d_req_we = want_d_we;
        d_req_wdata = rand_blk(); want_d = 1'b0;
      end else if (rand_en && $urandom_range(0, 3) == 0) begin
        d_req_valid = 1'b1; d_req_addr = rand_addr(); d_req_we = 1'($urandom_range(0, 1));
        d_req_wdata = rand_blk();
      end
    end
    case (l2_rdy_mode)
      1:       l2_req_ready = 1'b1;
      2:       l2_req_ready = 1'b0;
      default: l2_req_ready = 1'($urandom_range(0, 1));
    endcase
    l2_resp_valid = m_issued && (m_wait >= m_resp_delay);
    l2_resp_rdata = rand_blk();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_i_ready"}, blk_t'(i_req_ready), '0);
    check({tag, "_d_ready"}, blk_t'(d_req_ready), '0);
    check({tag, "_l2_valid"}, blk_t'(l2_req_valid), '0);
    check({tag, "_l2_addr"}, blk_t'(l2_req_addr), '0);
    check({tag, "_l2_we"}, blk_t'(l2_req_we), '0);
    check({tag, "_l2_wdata"}, l2_req_wdata, '0);
    check({tag, "_i_resp_valid"}, blk_t'(i_resp_valid), '0);
    check({tag, "_d_resp_valid"}, blk_t'(d_resp_valid), '0);
    check({tag, "_i_resp_data"}, i_resp_data, '0);
    check({tag, "_d_resp_data"}, d_resp_data, '0);
    check({tag, "_state"}, blk_t'(dbg_state), blk_t'(IDLE));
  endtask

  // Compare every output against the model, then advance the model past the next edge.
  task automatic check_cycle();
    bit exp_gi, exp_gd, hazard, d_wins, exp_l2v, exp_ir, exp_dr;
    if (rst) begin
      check_all_zero("rst");
      return;
    end
    exp_gi = 1'b0;
    exp_gd = 1'b0;
    if (!m_busy) begin
      hazard = d_req_valid && d_req_we && i_req_valid &&
               ((d_req_addr >> OFFSET_W) == (i_req_addr >> OFFSET_W));
`ifdef L2_ARB_RR_EN
      d_wins = hazard ? 1'b1 : !m_last_d;
`else
      d_wins = 1'b1;
`endif
      if (d_req_valid && i_req_valid) begin
        exp_gd = d_wins;
        exp_gi = !d_wins;
      end else begin
        exp_gd = d_req_valid;
        exp_gi = i_req_valid;
      end
    end
    check("i_req_ready", blk_t'(i_req_ready), blk_t'(exp_gi));
    check("d_req_ready", blk_t'(d_req_ready), blk_t'(exp_gd));

    exp_l2v = m_busy && !m_issued;
    check("l2_req_valid", blk_t'(l2_req_valid), blk_t'(exp_l2v));
    if (exp_l2v) begin
      check("l2_req_addr", blk_t'(l2_req_addr), blk_t'(m_addr));
      check("l2_req_we", blk_t'(l2_req_we), blk_t'(m_we));
      if (m_we) check("l2_req_wdata", l2_req_wdata, m_wdata);
    end

    exp_ir = m_issued && l2_resp_valid && !m_owner_d;
    exp_dr = m_issued && l2_resp_valid && m_owner_d;
    check("i_resp_valid", blk_t'(i_resp_valid), blk_t'(exp_ir));
    check("d_resp_valid", blk_t'(d_resp_valid), blk_t'(exp_dr));
    if (exp_ir) check("i_resp_data", i_resp_data, l2_resp_rdata);
    if (exp_dr) check("d_resp_data", d_resp_data, m_we ? blk_t'(0) : l2_resp_rdata);
    if (i_resp_valid) n_iresp_obs++;
    if (d_resp_valid) n_dresp_obs++;

    if (exp_gd || exp_gi) begin
      m_busy    = 1'b1;
      m_issued  = 1'b0;
      m_owner_d = exp_gd;
      m_addr    = exp_gd ? d_req_addr : i_req_addr;
      m_we      = exp_gd ? d_req_we : 1'b0;
      m_wdata   = d_req_wdata;
      m_last_d  = exp_gd;
      m_resp_delay = (resp_delay_fixed >= 0) ? resp_delay_fixed : $urandom_range(0, 4);
      exp_q.push_back(m_addr);
      win_log.push_back(exp_gd ? 1 : 0);
      if (exp_gd) drop_d = 1'b1; else drop_i = 1'b1;
    end else if (m_busy && !m_issued && l2_req_ready) begin
      m_issued = 1'b1;
      m_wait   = 0;
      if (exp_q.size() == 0) check("l2_handshake_unexpected", blk_t'(1), blk_t'(0));
      else check("l2_handshake_addr", blk_t'(l2_req_addr), blk_t'(exp_q.pop_front()));
    end else if (m_issued) begin
      if (l2_resp_valid) begin
        m_busy   = 1'b0;
        m_issued = 1'b0;
      end else begin
        m_wait++;
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk); #1;
    drive();
    @(negedge clk);
    check_cycle();
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((m_busy || i_req_valid || d_req_valid || want_i || want_d) && n < budget) begin
      cycle();
      n++;
    end
    if (n >= budget) check("wait_idle_timeout", blk_t'(1), blk_t'(0));
  endtask

  task automatic model_reset();
    m_busy = 0; m_issued = 0; m_owner_d = 0; m_we = 0; m_last_d = 0;
    m_addr = '0; m_wdata = '0; m_wait = 0; m_resp_delay = 0;
    drop_i = 0; drop_d = 0;
    exp_q.delete();
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int n0_i, n0_d, n0_log, n;
    rst = 1'b1;
    i_req_valid = 0; i_req_addr = '0; d_req_valid = 0; d_req_addr = '0; d_req_we = 0;
    d_req_wdata = '0; l2_req_ready = 0; l2_resp_valid = 0; l2_resp_rdata = '0;
    rand_en = 0; l2_rdy_mode = 1; resp_delay_fixed = 1;
    want_i = 0; want_d = 0; want_d_we = 0; want_i_addr = '0; want_d_addr = '0;
    n_iresp_obs = 0; n_dresp_obs = 0;
    model_reset();
    #1;
    check_all_zero("reset");
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Lone I refill, L2 ready at once.
    n0_i = n_iresp_obs; n0_d = n_dresp_obs;
    want_i = 1; want_i_addr = 32'h0000_1080;
    wait_idle(50);
    check("lone_i_resp_count", blk_t'(n_iresp_obs - n0_i), blk_t'(1));
    check("lone_i_no_d_resp", blk_t'(n_dresp_obs - n0_d), blk_t'(0));

    // Two contention rounds, no hazard.
    for (int r = 0; r < 2; r++) begin
      n0_log = win_log.size();
      want_i = 1; want_i_addr = 32'h0000_3000;
      want_d = 1; want_d_addr = 32'h0000_4000; want_d_we = 0;
      wait_idle(50);
      check("contention_accepts", blk_t'(win_log.size() - n0_log), blk_t'(2));
    end

    // Lone D writeback leaves last-winner = D, then the hazard pair.
    n0_d = n_dresp_obs;
    want_d = 1; want_d_addr = 32'h0000_5000; want_d_we = 1;
    wait_idle(50);
    check("wb_ack_count", blk_t'(n_dresp_obs - n0_d), blk_t'(1));
    n0_log = win_log.size();
    want_d = 1; want_d_addr = 32'h0000_2000; want_d_we = 1;
    want_i = 1; want_i_addr = 32'h0000_2040;
    wait_idle(50);
    check("hazard_first_winner_d", blk_t'(win_log[n0_log]), blk_t'(1));
    check("hazard_then_i", blk_t'(win_log[n0_log + 1]), blk_t'(0));

    // L2 stalls 5 cycles with both requesters waiting.
    l2_rdy_mode = 2;
    want_i = 1; want_i_addr = 32'h0000_6000;
    want_d = 1; want_d_addr = 32'h0000_7000; want_d_we = 1;
    n = 0;
    while (!m_busy && n < 20) begin cycle(); n++; end
    check("stall_accepted", blk_t'(m_busy), blk_t'(1));
    repeat (5) cycle();
    l2_rdy_mode = 1;
    wait_idle(50);

    // Reset while waiting for the L2 response; a held I request follows.
    resp_delay_fixed = 20;
    want_d = 1; want_d_addr = 32'h0000_8000; want_d_we = 0;
    n = 0;
    while (!m_issued && n < 20) begin cycle(); n++; end
    check("reach_wait", blk_t'(m_issued), blk_t'(1));
    @(posedge clk); #1;
    rst = 1'b1; l2_resp_valid = 0; d_req_valid = 0;
    i_req_valid = 1; i_req_addr = 32'h0000_9000;
    #1;
    check_all_zero("rst_in_wait");
    model_reset();
    @(negedge clk);
    check_cycle();
    @(posedge clk); #1;
    rst = 1'b0;
    resp_delay_fixed = 1;
    n0_log = win_log.size();
    @(negedge clk);
    check_cycle();
    check("post_reset_i_accepted", blk_t'(win_log.size() - n0_log), blk_t'(1));
    wait_idle(50);

    // Randomized traffic.
    resp_delay_fixed = -1; l2_rdy_mode = 0; rand_en = 1;
    repeat (3000) cycle();
    rand_en = 0;
    wait_idle(200);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global time limit so the bench always terminates.
  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
